// File: rtl/vz_loader.sv
// VZ snapshot loader: parses the HPS download and writes the payload to RAM with the Z80 held (macro VZ_BASIC_PATCH_EN adds the BASIC end-pointer patch).
// Latency: RAM write 1 cycle after dn_wr; hold release 1 cycle (F1, unpatched F0) or 3 cycles (patched F0) after dn_download falls.
// Backpressure: none; dn_wr strobes must be at least 2 cycles apart.
module vz_loader #(
   parameter logic [7:0]  DN_INDEX     = 8'd1,
   parameter logic [15:0] END_PTR_ADDR = 16'h78F9
) (
   input  logic        CLK10MHZ,
   input  logic        RESET,
   input  logic        dn_download,
   input  logic [7:0]  dn_index,
   input  logic        dn_wr,
   input  logic [15:0] dn_addr,
   input  logic [7:0]  dn_data,
   output logic        ram_we,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_dout,
   output logic        cpu_hold,
   output logic        exec_valid,
   output logic [15:0] exec_pc,
   output logic        err,
   output logic        led
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
`ifdef VZ_BASIC_PATCH_EN
      S_PATCH_LO,
      S_PATCH_HI,
`endif
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state_q, state_d;
   logic        dl_q;
   logic        fall_pend_q, fall_pend_d;
   logic [15:0] start_q, start_d;
   logic        type_f1_q, type_f1_d;
   logic        vzf_q, vzf_d, spc_q, spc_d;
   logic        ram_we_d, cpu_hold_d, exec_valid_d, err_d;
   logic [15:0] ram_addr_d, exec_pc_d;
   logic [7:0]  ram_dout_d;
   logic        rise, fall, efall, finish, hdr_bad;
   logic [7:0]  vzf_byte, spc_byte;
   logic [16:0] pay_addr;

   assign rise     = dn_download & ~dl_q;
   assign fall     = ~dn_download & dl_q;
   assign efall    = fall | fall_pend_q;
   assign pay_addr = {1'b0, start_q} + ({1'b0, dn_addr} - 17'd24);
   assign spc_byte = dn_addr[1] ? 8'h00 : 8'h20;
   assign led      = cpu_hold;

   always_comb begin
      case (dn_addr[1:0])
         2'd0:    vzf_byte = 8'h56;
         2'd1:    vzf_byte = 8'h5A;
         2'd2:    vzf_byte = 8'h46;
         default: vzf_byte = 8'h30;
      endcase
   end

`ifdef VZ_BASIC_PATCH_EN
   logic [15:0] len_q;
   logic [15:0] end_ptr;
   assign end_ptr = start_q + len_q;

   always_ff @(posedge CLK10MHZ or negedge RESET) begin
      if (!RESET)
         len_q <= '0;
      else if (state_q == S_IDLE)
         len_q <= '0;
      else if (state_q == S_DATA && dn_wr && dn_addr >= 16'd24)
         len_q <= len_q + 16'd1;
   end
`endif

   always_comb begin
      state_d      = state_q;
      fall_pend_d  = 1'b0;
      start_d      = start_q;
      type_f1_d    = type_f1_q;
      vzf_d        = vzf_q;
      spc_d        = spc_q;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr;
      ram_dout_d   = ram_dout;
      cpu_hold_d   = cpu_hold;
      exec_valid_d = 1'b0;
      exec_pc_d    = exec_pc;
      err_d        = err;
      hdr_bad      = 1'b0;
      finish       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rise && dn_index == DN_INDEX) begin
               state_d    = S_HDR;
               cpu_hold_d = 1'b1;
               err_d      = 1'b0;
               vzf_d      = 1'b1;
               spc_d      = 1'b1;
               type_f1_d  = 1'b0;
            end
         end
         S_HDR: begin
            if (dn_wr && dn_addr < 16'd24) begin
               if (dn_addr < 16'd4) begin
                  vzf_d   = vzf_q & (dn_data == vzf_byte);
                  spc_d   = spc_q & (dn_data == spc_byte);
                  hdr_bad = ~(vzf_d | spc_d);
               end else if (dn_addr == 16'd21) begin
                  type_f1_d = (dn_data == 8'hF1);
                  hdr_bad   = (dn_data != 8'hF0) && (dn_data != 8'hF1);
               end else if (dn_addr == 16'd22) begin
                  start_d[7:0] = dn_data;
               end else if (dn_addr == 16'd23) begin
                  start_d[15:8] = dn_data;
                  state_d       = S_DATA;
                  // a download ending on the last header byte is finished from DATA
                  fall_pend_d   = fall;
               end
            end
            if (hdr_bad || (fall && state_d == S_HDR)) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
            end
         end
         S_DATA: begin
            if (dn_wr && dn_addr >= 16'd24) begin
               if (pay_addr[16]) begin
                  err_d = 1'b1;
               end else begin
                  ram_we_d   = 1'b1;
                  ram_addr_d = pay_addr[15:0];
                  ram_dout_d = dn_data;
               end
            end
            // the byte owns this cycle's write port; act on the edge one cycle later
            if (efall) begin
               if (dn_wr) fall_pend_d = 1'b1;
               else       finish      = 1'b1;
            end
         end
`ifdef VZ_BASIC_PATCH_EN
         S_PATCH_LO: begin
            state_d    = S_PATCH_HI;
            ram_we_d   = 1'b1;
            ram_addr_d = END_PTR_ADDR + 16'd1;
            ram_dout_d = end_ptr[15:8];
         end
         S_PATCH_HI: begin
            state_d    = S_DONE;
            cpu_hold_d = 1'b0;
         end
`endif
         S_DONE: state_d = S_IDLE;
         S_ERROR: begin
            if (!dn_download) begin
               cpu_hold_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (finish) begin
         if (type_f1_q) begin
            state_d      = S_DONE;
            cpu_hold_d   = 1'b0;
            exec_valid_d = 1'b1;
            exec_pc_d    = start_q;
         end else begin
`ifdef VZ_BASIC_PATCH_EN
            state_d    = S_PATCH_LO;
            ram_we_d   = 1'b1;
            ram_addr_d = END_PTR_ADDR;
            ram_dout_d = end_ptr[7:0];
`else
            state_d    = S_DONE;
            cpu_hold_d = 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge CLK10MHZ or negedge RESET) begin
      if (!RESET) begin
         state_q     <= S_IDLE;
         // a download already high when reset lifts must not look like a new one
         dl_q        <= 1'b1;
         fall_pend_q <= 1'b0;
         start_q     <= '0;
         type_f1_q   <= 1'b0;
         vzf_q       <= 1'b0;
         spc_q       <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_dout    <= '0;
         cpu_hold    <= 1'b0;
         exec_valid  <= 1'b0;
         exec_pc     <= '0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_d;
         dl_q        <= dn_download;
         fall_pend_q <= fall_pend_d;
         start_q     <= start_d;
         type_f1_q   <= type_f1_d;
         vzf_q       <= vzf_d;
         spc_q       <= spc_d;
         ram_we      <= ram_we_d;
         ram_addr    <= ram_addr_d;
         ram_dout    <= ram_dout_d;
         cpu_hold    <= cpu_hold_d;
         exec_valid  <= exec_valid_d;
         exec_pc     <= exec_pc_d;
         err         <= err_d;
      end
   end

endmodule

// File: doc/vz_loader.md
# vz_loader

Parses a VZ snapshot streamed from the HPS download channel (menu file index 1) and writes its payload into Laser310 system RAM while holding the Z80. It sits between the HPS ioctl download stream and the RAM write port inside `LASER310_TOP`. For BASIC images it patches the BASIC end-of-program pointer. For machine-code images it raises a one-cycle execute request carrying the load address.

## Interface
Parameters:
- `DN_INDEX`, 8'd1: ioctl index identifying VZ images.
- `END_PTR_ADDR`, 16'h78F9: RAM address of the BASIC end-of-program pointer, stored little-endian.

Ports:
- `CLK10MHZ` in 1: system clock; only clock.
- `RESET` in 1: asynchronous, active-low reset.
- `dn_download` in 1: download active, level.
- `dn_index` in 8: download file index.
- `dn_wr` in 1: one-cycle byte strobe.
- `dn_addr` in 16: byte offset within the file.
- `dn_data` in 8: byte value.
- `ram_we` out 1: RAM write strobe, one cycle.
- `ram_addr` out 16: RAM write address.
- `ram_dout` out 8: RAM write data.
- `cpu_hold` out 1: holds the Z80 (WAIT/BUSRQ) while high.
- `exec_valid` out 1: one-cycle pulse; a type-F1 image loaded successfully.
- `exec_pc` out 16: start address, valid while `exec_valid` is high and held afterwards.
- `err` out 1: last load failed; sticky until the next load starts.
- `led` out 1: equals `cpu_hold`.

## Operation
VZ layout:
- Bytes 0–3: magic. Accept either 'V','Z','F','0' or 20h,20h,00h,00h.
- Bytes 4–20: name. Ignored.
- Byte 21: type. F0h = BASIC, F1h = binary; any other value is an error.
- Bytes 22–23: start address, little-endian.
- Bytes 24 and above: payload.

States: IDLE, HDR, DATA, PATCH_LO, PATCH_HI, DONE, ERROR.
- IDLE → HDR on the rising edge of `dn_download` while `dn_index == DN_INDEX`. On entry: `cpu_hold`=1, `err`=0, internal length counter cleared. Other indices are ignored entirely.
- HDR: each `dn_wr` with `dn_addr` < 24 is checked or latched by offset.
  - Magic mismatch or bad type byte → ERROR immediately.
  - Strobe at offset 23 → DATA.
- DATA: each `dn_wr` writes `dn_data` to `start + (dn_addr − 24)`.
  - Address is computed in 17 bits. If bit 16 is set, the byte is dropped, `err`=1, and the state stays DATA (overflow, no wrap).
  - The length counter increments on every payload byte.
- Falling edge of `dn_download`:
  - In HDR → ERROR (truncated header).
  - In DATA with type F0 → PATCH_LO.
  - In DATA with type F1 → DONE, with `exec_valid` pulsed.
- PATCH_LO writes `(start+len)[7:0]` to `END_PTR_ADDR`. PATCH_HI writes `(start+len)[15:8]` to `END_PTR_ADDR+1`. Sum is 16-bit, wraps. Then DONE.
- DONE / ERROR: drop `cpu_hold`, then return to IDLE the next cycle. `err` is set on the ERROR path and holds.
- ERROR absorbs the remaining strobes of the failed download and waits for `dn_download` low before returning to IDLE. No RAM writes occur in ERROR.
- An overflowing F1 load still pulses `exec_valid`, with `err`=1.

## Timing
- Reset values: all outputs 0, state IDLE. Asserting `RESET` mid-load aborts immediately; no patch and no exec pulse follow.
- `ram_we` is registered: it is high exactly in the cycle after the accepted `dn_wr`, with `ram_addr`/`ram_dout` valid that cycle.
- `dn_wr` strobes are at least 2 cycles apart. Back-to-back strobes on consecutive cycles are not supported.
- `dn_download` edge detection uses a registered copy. An edge and a `dn_wr` in the same cycle: the byte is processed first.
- PATCH_LO/PATCH_HI each occupy one cycle and produce `ram_we` on consecutive cycles. `cpu_hold` falls in the cycle after PATCH_HI's write.
- Latency from the falling edge of `dn_download` to `cpu_hold`=0: 3 cycles for F0, 1 cycle for F1.
- `exec_valid` is coincident with the cycle `cpu_hold` falls.

## Configuration
- `VZ_BASIC_PATCH_EN`
  - Defined: F0 loads run PATCH_LO/PATCH_HI as above.
  - Undefined: those states are not built. F0 loads go DATA → DONE directly with no pointer write; `cpu_hold` falls 1 cycle after the edge. F1 behaviour is unchanged.

## Test plan
- Valid "VZF0" header, type F0, start 7AE9h, 5 payload bytes → five writes at 7AE9h–7AEDh; then 78F9h←EEh and 78FAh←7Ah; `err`=0; `exec_valid` never pulses.
- Type F1, start 8000h, 3 bytes → writes at 8000h–8002h; `exec_valid` pulse with `exec_pc`=8000h; no write to 78F9h.
- Magic "VZX0" → `err`=1 after offset 2; zero `ram_we` for the whole file; `cpu_hold` released only after `dn_download` falls.
- Start FFFEh, 4 bytes → writes only at FFFEh and FFFFh; `err`=1; F1 `exec_valid` still pulses.
- `RESET` low during DATA after 2 bytes → all outputs 0 immediately; no further writes when strobes continue with `RESET` high.
- `dn_index`=0 download → no outputs change; `cpu_hold` stays 0.
